l1_input_loader: RTL
====================

# l1_input_loader

Upstream feeder for the first conv/pool stage. Accepts a pixel stream with a valid/ready handshake and packs each image row into a 384-bit word. Writes the 32 rows into the L1 input row memory at addresses 0..31. It then holds `l1_en` high until the conv/pool stage reports `l1_done`, and returns to idle for the next frame.

## Interface

Parameters:
- `DATA_WIDTH`, 12: pixel width.
- `IMG_W`, 32: row length written to memory, in pixels.
- `IMG_H`, 32: rows per frame.
- `PAD`, 2: zero border width, used only when padding is compiled in.
- `ROW_WIDTH`, `DATA_WIDTH*IMG_W` (384): memory word width.

Ports. Reset is `rst`, synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  frame start request; sampled only in IDLE
- `s_valid`  in  1  pixel valid
- `s_data`  in  DATA_WIDTH  pixel value
- `s_last`  in  1  marks the final pixel of the frame
- `s_ready`  out  1  loader accepts the pixel this cycle
- `mem_we`  out  1  row write strobe
- `mem_addr`  out  5  row address, 0..31
- `mem_din`  out  ROW_WIDTH  packed row
- `l1_en`  out  1  enable for the conv/pool stage
- `l1_done`  in  1  conv/pool stage finished
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse at handoff completion
- `frame_err`  out  1  sticky `s_last` mismatch flag

## Operation

States are IDLE, FILL, WRITE and RUN, held as a one-hot register.

- **IDLE:** `s_ready`=0.
  - `start`=1 moves to FILL.
  - On that transition, row=0, col=0 and `frame_err`=0.
- **FILL:** one pixel position per cycle, col 0..31.
  - A pixel at column c lands in row buffer bits `[c*DATA_WIDTH +: DATA_WIDTH]`, so column 0 is in the LSBs.
  - Without padding: `s_ready`=1, and col advances only on accept (`s_valid`&`s_ready`).
  - When col 31 is filled, the state moves to WRITE.
- **WRITE:** single cycle.
  - `mem_we`=1, `mem_addr`=row, `mem_din`=row buffer, `s_ready`=0.
  - If row==31, move to RUN; otherwise row+1, col=0, and return to FILL.
- **RUN:** `l1_en`=1 and `s_ready`=0.
  - When `l1_done`=1 is sampled, move to IDLE and pulse `frame_done` for 1 cycle.
  - `l1_en` is 0 from the IDLE cycle onward.

Rules that apply in every state:
- **`frame_err`:** set when `s_last` is accepted on any pixel other than the frame's last accepted pixel. Also set when the last pixel is accepted with `s_last`=0. It stays set until the next `start`.
  - Counting never resynchronises on `s_last`.
- **`start` while `busy`:** ignored.
- **`l1_done` outside RUN:** ignored.
- **`rst`, at any time including mid-frame or in RUN:** the next state is IDLE.
  - The row buffer and counters clear, and no further `mem_we` is issued.
- **Counter wrap:** row and col are 5-bit and never wrap within a frame. The transitions above bound them.

## Timing

Reset values:
- `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- `l1_en`=0, `busy`=0, `frame_done`=0, `frame_err`=0.

Output timing:
- All outputs are registered or decoded from registered state.
- `s_ready` depends on state only, never on `s_valid`.
- `mem_din` and `mem_addr` are stable during the `mem_we` cycle and hold their values afterwards.

Latency:
- `busy` rises the cycle after `start`.
- The first `mem_we` comes the cycle after the row's 32nd pixel is accepted.
- Without padding and with continuous `s_valid`, a frame takes 32×(32+1)=1056 cycles from the first FILL cycle to RUN entry.
- `l1_en` rises in the first RUN cycle. This is the cycle after the row-31 write.

## Configuration

Macro: `LOADER_PAD_EN`.

Defined:
- The stream carries (IMG_W−2·PAD)×(IMG_H−2·PAD) = 28×28 = 784 pixels.
- In FILL, a position with row<PAD, row≥IMG_H−PAD, col<PAD or col≥IMG_W−PAD is a zero-insert cycle. In that cycle `s_ready`=0, zero is written into the buffer, and col advances unconditionally.
- Every other position behaves as in the unpadded case.
- With continuous `s_valid`, a frame takes exactly 1056 cycles.

Undefined:
- The stream carries 32×32 = 1024 pixels and no zeros are inserted.

## Test plan

- **Unpadded ramp frame:** continuous valid with pixel value = (row·32+col) mod 4096 and `s_last` on beat 1024.
  - Expect 32 `mem_we` pulses at addresses 0..31.
  - Expect row 5 bits `[11:0]`=160 and bits `[383:372]`=191.
  - Expect `frame_err`=0 and `l1_en`=1 after the final write.
- **Handoff:** hold `l1_done`=0 for 50 RUN cycles, then 1.
  - Expect `l1_en` high throughout, then low the next cycle, with a `frame_done` pulse of 1 cycle.
- **Stall:** toggle `s_valid` every other cycle.
  - Expect identical memory contents, the final write delayed accordingly, and no accepts during WRITE cycles.
- **`s_last` errors:** raise `s_last` on beat 500, and separately omit it on beat 1024.
  - Expect `frame_err`=1 after that beat in both cases, and all 32 rows still written.
- **Reset and ignored start:** assert `rst` mid-row 10, and pulse `start` during FILL.
  - Expect IDLE with all outputs at reset values, no further writes, and `start` during FILL having no effect.
- **`LOADER_PAD_EN`:** send 784 pixels of value 0xFFF.
  - Expect rows 0, 1, 30 and 31 all zero.
  - Expect row 2 with bits `[23:0]`=0, bits `[359:24]` all ones and bits `[383:360]`=0.
  - Expect the frame to complete in 1056 cycles.

Source files
------------

// File: rtl/l1_input_loader.sv
// Pixel-stream loader for the first conv/pool stage: packs each image row into one memory word,
// writes all rows, then hands off via l1_en/l1_done. Optional zero border: define LOADER_PAD_EN.
module l1_input_loader #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int PAD        = 2,
    parameter int ROW_WIDTH  = DATA_WIDTH * IMG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [4:0]            mem_addr,
    output logic [ROW_WIDTH-1:0]  mem_din,
    output logic                  l1_en,
    input  logic                  l1_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FILL  = 4'b0010,
        WRITE = 4'b0100,
        RUN   = 4'b1000
    } state_t;

`ifdef LOADER_PAD_EN
    localparam int EDGE = PAD;
`else
    localparam int EDGE = 0;
`endif

    localparam logic [4:0] COL_LAST     = 5'(IMG_W - 1);
    localparam logic [4:0] ROW_LAST     = 5'(IMG_H - 1);
    localparam logic [4:0] PIX_COL_LAST = 5'(IMG_W - 1 - EDGE);
    localparam logic [4:0] PIX_ROW_LAST = 5'(IMG_H - 1 - EDGE);

    state_t                 state_q, state_d;
    logic [4:0]             row_q, col_q, addr_q;
    logic [ROW_WIDTH-1:0]   buf_q, buf_d, din_q;
    logic                   err_q, done_q;
    logic                   pad_pos, accept, advance, last_pos;

    // Border positions are filled with zero without consuming a stream beat.
    always_comb begin
        pad_pos  = (int'(row_q) < EDGE) || (int'(row_q) >= IMG_H - EDGE) ||
                   (int'(col_q) < EDGE) || (int'(col_q) >= IMG_W - EDGE);
        s_ready  = (state_q == FILL) && !pad_pos;
        accept   = s_valid && s_ready;
        advance  = (state_q == FILL) && (accept || pad_pos);
        last_pos = (row_q == PIX_ROW_LAST) && (col_q == PIX_COL_LAST);
        buf_d    = buf_q;
        buf_d[int'(col_q)*DATA_WIDTH +: DATA_WIDTH] = pad_pos ? '0 : s_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (advance && col_q == COL_LAST) state_d = WRITE;
            WRITE:   state_d = (row_q == ROW_LAST) ? RUN : FILL;
            RUN:     if (l1_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == RUN) && l1_done;
            if (state_q == IDLE && start) begin
                row_q <= '0;
                col_q <= '0;
                err_q <= 1'b0;
            end
            if (accept && (s_last != last_pos))
                err_q <= 1'b1;
            if (advance) begin
                buf_q <= buf_d;
                if (col_q == COL_LAST) begin
                    // Snapshot the completed row so mem_din/mem_addr hold after the write.
                    din_q  <= buf_d;
                    addr_q <= row_q;
                end else begin
                    col_q <= col_q + 5'd1;
                end
            end
            if (state_q == WRITE && row_q != ROW_LAST) begin
                row_q <= row_q + 5'd1;
                col_q <= '0;
            end
        end
    end

    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign l1_en      = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
